pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Program-counter register with parametrised next-address selection, the successor to the combinational jump/branch/register address mux. Sits at the front of the fetch stage. Each cycle it either advances the PC sequentially or redirects it to a jump, branch or register target. A redirect that arrives while fetch is stalled is buffered and applied when the stall lifts, so no control-flow change is lost.

## Interface
Parameters:
- NBITS, 32, address width.
- SELBITS, 2, width of the target selector.
- RESET_ADDR, 0, PC value after reset.
- INC, 4, sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- halt  in  1  enter HALTED; PC frozen until reset.
- redirect_valid  in  1  redirect request this cycle.
- sel_addr  in  SELBITS  target select: 00 jump, 01 branch, 10 reg, 11 reserved.
- jump_addr  in  NBITS  unconditional-jump target.
- branch_addr  in  NBITS  taken-branch target.
- reg_addr  in  NBITS  register-jump target.
- pc  out  NBITS  current PC, registered.
- flush  out  1  registered one-cycle pulse; high in the first cycle pc shows a redirect target.
- pending  out  1  a buffered redirect is waiting.
- sel_err  out  1  sticky flag: a reserved selector was seen with redirect_valid high.
- halted  out  1  high in state HALTED.

## Operation
- States: RUN, HOLD (redirect buffered), HALTED.
- target = mux(sel_addr); it is valid only when sel_addr != 11.
- A valid redirect (vr) is redirect_valid high with a valid target.
- A reserved selector with redirect_valid high is dropped: it is treated as "no redirect", sets sel_err, and never produces the old all-ones address.
- Priority, highest first: reset, halt, vr, sequential advance.
- Any state, halt=1: next state is HALTED, the buffer is discarded, pending goes to 0, and pc holds.
- HALTED: pc, flush=0 and pending=0 hold until reset. All other inputs are ignored.
- RUN:
  - vr and stall=0: pc <= target, flush <= 1.
  - vr and stall=1: buf <= target, pending <= 1, go to HOLD; pc holds.
  - no vr and stall=0: pc <= pc + INC, computed modulo 2^NBITS (wraps, no carry out).
  - no vr and stall=1: hold.
- HOLD:
  - stall=1: pc holds. A new vr overwrites buf (newest wins); pending stays 1.
  - stall=0: pc <= (vr ? target : buf), flush <= 1, pending <= 0, go to RUN.
- flush is 0 in every cycle not listed above.
- sel_err clears only on reset.

## Timing
- Reset values: pc=RESET_ADDR, flush=0, pending=0, sel_err=0, halted=0, state RUN, buf=0.
- reset applies at the edge where it is sampled high and overrides every other input that cycle. Reset during HOLD or HALTED discards the buffer.
- Latency: one cycle from a sampled vr (not stalled) to pc=target with flush=1.
- For a buffered redirect: pc=buf and flush=1 in the cycle after the first edge at which stall is sampled 0.
- pending rises the cycle after a stalled vr and falls in the same cycle flush rises.
- halted rises the cycle after halt is sampled.
- Sequential advance: pc + INC at every unstalled edge without a redirect. 0xFFFFFFFC + 4 gives 0x00000000.

## Test plan
- Reset then 3 free cycles: pc goes 0 -> 4 -> 8 -> 12, flush=0 throughout. Start pc at 0xFFFFFFF8 via a redirect: pc goes 0xFFFFFFF8 -> 0xFFFFFFFC -> 0x0.
- Redirect each selector, unstalled: sel=00 with jump_addr=0x100 gives pc=0x100 and flush=1 for one cycle. Repeat with sel=01/branch_addr=0x200 (pc=0x200) and sel=10/reg_addr=0x300 (pc=0x300).
- Stalled redirect:
  - stall=1 with a jump to 0x400: next cycle pending=1 and pc unchanged.
  - Hold stall 3 more cycles, then stall=0: pc=0x400, flush=1, pending=0.
- Overwrite in HOLD: buffer 0x400, then a branch to 0x500 while still stalled, then release: pc=0x500, with exactly one flush pulse.
- Reserved selector: redirect_valid=1, sel=11: pc advances by 4, sel_err=1 and stays 1 until reset.
- Halt and reset: halt while pending=1 gives halted=1, pending=0, pc frozen for 10 cycles. Then reset gives pc=RESET_ADDR and all flags 0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch-stage program counter: sequential advance or redirect to a jump, branch
// or register target, with a one-entry buffer for redirects that arrive during a stall.
module pc_redirect_unit #(
  parameter int unsigned           NBITS      = 32,
  parameter int unsigned           SELBITS    = 2,
  parameter logic [NBITS-1:0]      RESET_ADDR = '0,
  parameter int unsigned           INC        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [SELBITS-1:0] sel_addr,
  input  logic [NBITS-1:0]   jump_addr,
  input  logic [NBITS-1:0]   branch_addr,
  input  logic [NBITS-1:0]   reg_addr,
  output logic [NBITS-1:0]   pc,
  output logic               flush,
  output logic               pending,
  output logic               sel_err,
  output logic               halted
);

  localparam logic [SELBITS-1:0] SEL_JUMP   = SELBITS'(0);
  localparam logic [SELBITS-1:0] SEL_BRANCH = SELBITS'(1);
  localparam logic [SELBITS-1:0] SEL_REG    = SELBITS'(2);
  localparam logic [SELBITS-1:0] SEL_RSV    = SELBITS'(3);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [NBITS-1:0] r_pc, w_pc_nxt;
  logic [NBITS-1:0] r_buf, w_buf_nxt;
  logic             r_flush, w_flush_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_sel_err, w_sel_err_nxt;

  logic [NBITS-1:0] w_target;
  logic             w_vr;
  logic             w_rsv;

  // Target mux; the reserved code yields zero and is never a valid redirect.
  always_comb begin
    w_target = '0;
    case (sel_addr)
      SEL_JUMP:   w_target = jump_addr;
      SEL_BRANCH: w_target = branch_addr;
      SEL_REG:    w_target = reg_addr;
      default:    w_target = '0;
    endcase
  end

  assign w_rsv = redirect_valid && (sel_addr == SEL_RSV);
  assign w_vr  = redirect_valid && (sel_addr != SEL_RSV);

  // Next-state and next-register logic; halt outranks any redirect.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_flush_nxt   = 1'b0;
    w_pending_nxt = r_pending;
    w_sel_err_nxt = r_sel_err;

    if (r_state == S_HALTED) begin
      w_pending_nxt = 1'b0;
    end else if (halt) begin
      w_state_nxt   = S_HALTED;
      w_buf_nxt     = '0;
      w_pending_nxt = 1'b0;
    end else begin
      if (w_rsv) w_sel_err_nxt = 1'b1;
      case (r_state)
        S_RUN: begin
          if (w_vr && !stall) begin
            w_pc_nxt    = w_target;
            w_flush_nxt = 1'b1;
          end else if (w_vr) begin
            w_buf_nxt     = w_target;
            w_pending_nxt = 1'b1;
            w_state_nxt   = S_HOLD;
          end else if (!stall) begin
            w_pc_nxt = r_pc + NBITS'(INC);
          end
        end
        S_HOLD: begin
          if (stall) begin
            if (w_vr) w_buf_nxt = w_target;
          end else begin
            w_pc_nxt      = w_vr ? w_target : r_buf;
            w_flush_nxt   = 1'b1;
            w_pending_nxt = 1'b0;
            w_state_nxt   = S_RUN;
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_ADDR;
      r_buf     <= '0;
      r_flush   <= 1'b0;
      r_pending <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_buf     <= w_buf_nxt;
      r_flush   <= w_flush_nxt;
      r_pending <= w_pending_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  assign pc      = r_pc;
  assign flush   = r_flush;
  assign pending = r_pending;
  assign sel_err = r_sel_err;
  assign halted  = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, halt/reset sequence,
// then randomized traffic checked against a behavioural model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, stall, halt, redirect_valid;
  logic [1:0]  sel_addr;
  logic [31:0] jump_addr, branch_addr, reg_addr;
  logic [31:0] pc;
  logic        flush, pending, sel_err, halted;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_buf;
  logic        m_flush, m_pending, m_err, m_halted;

  pc_redirect_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .redirect_valid(redirect_valid), .sel_addr(sel_addr),
    .jump_addr(jump_addr), .branch_addr(branch_addr), .reg_addr(reg_addr),
    .pc(pc), .flush(flush), .pending(pending), .sel_err(sel_err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, hlt, rv;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] e_pc;
    logic        e_flush, e_pend, e_err, e_halt;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic rst, stl, hlt, rv, input logic [1:0] sel,
                              input logic [31:0] addr, input logic [31:0] e_pc,
                              input logic e_flush, e_pend, e_err, e_halt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.hlt = hlt; v.rv = rv; v.sel = sel; v.addr = addr;
    v.e_pc = e_pc; v.e_flush = e_flush; v.e_pend = e_pend; v.e_err = e_err; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, stl, hlt, rv, input logic [1:0] sel,
                            input logic [31:0] j, b, r);
    logic        have_t;
    logic [31:0] t;
    have_t = rv && (sel != 2'd3);
    t = (sel == 2'd0) ? j : (sel == 2'd1) ? b : r;
    if (rst) begin
      m_pc = 32'h0; m_buf = 32'h0; m_flush = 0; m_pending = 0; m_err = 0; m_halted = 0;
    end else if (m_halted) begin
      m_flush = 0;
    end else if (hlt) begin
      m_halted = 1; m_pending = 0; m_buf = 32'h0; m_flush = 0;
    end else begin
      if (rv && sel == 2'd3) m_err = 1;
      m_flush = 0;
      if (m_pending) begin
        if (stl) begin
          if (have_t) m_buf = t;
        end else begin
          m_pc = have_t ? t : m_buf;
          m_flush = 1;
          m_pending = 0;
        end
      end else if (have_t) begin
        if (stl) begin m_buf = t; m_pending = 1; end
        else begin m_pc = t; m_flush = 1; end
      end else if (!stl) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle before sampling.
  task automatic step(input logic rst, stl, hlt, rv, input logic [1:0] sel,
                      input logic [31:0] j, b, r);
    reset = rst; stall = stl; halt = hlt; redirect_valid = rv; sel_addr = sel;
    jump_addr = j; branch_addr = b; reg_addr = r;
    @(posedge clk);
    model_step(rst, stl, hlt, rv, sel, j, b, r);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},      pc,              m_pc);
    check({tag, ".flush"},   32'(flush),      32'(m_flush));
    check({tag, ".pending"}, 32'(pending),    32'(m_pending));
    check({tag, ".sel_err"}, 32'(sel_err),    32'(m_err));
    check({tag, ".halted"},  32'(halted),     32'(m_halted));
  endtask

  initial begin
    logic [31:0] j, b, r, base;
    logic [1:0]  s;
    logic        rst, stl, hlt, rv;

    tbl[0]  = mk(1,0,0,0,2'd0,32'h0,        32'h0,        0,0,0,0);
    tbl[1]  = mk(0,0,0,0,2'd0,32'h0,        32'h4,        0,0,0,0);
    tbl[2]  = mk(0,0,0,0,2'd0,32'h0,        32'h8,        0,0,0,0);
    tbl[3]  = mk(0,0,0,0,2'd0,32'h0,        32'hC,        0,0,0,0);
    tbl[4]  = mk(0,0,0,1,2'd0,32'hFFFFFFF8, 32'hFFFFFFF8, 1,0,0,0);
    tbl[5]  = mk(0,0,0,0,2'd0,32'h0,        32'hFFFFFFFC, 0,0,0,0);
    tbl[6]  = mk(0,0,0,0,2'd0,32'h0,        32'h0,        0,0,0,0);
    tbl[7]  = mk(0,0,0,1,2'd0,32'h100,      32'h100,      1,0,0,0);
    tbl[8]  = mk(0,0,0,0,2'd0,32'h0,        32'h104,      0,0,0,0);
    tbl[9]  = mk(0,0,0,1,2'd1,32'h200,      32'h200,      1,0,0,0);
    tbl[10] = mk(0,0,0,1,2'd2,32'h300,      32'h300,      1,0,0,0);
    tbl[11] = mk(0,0,0,0,2'd0,32'h0,        32'h304,      0,0,0,0);
    tbl[12] = mk(0,1,0,1,2'd0,32'h400,      32'h304,      0,1,0,0);
    tbl[13] = mk(0,1,0,0,2'd0,32'h0,        32'h304,      0,1,0,0);
    tbl[14] = mk(0,1,0,0,2'd0,32'h0,        32'h304,      0,1,0,0);
    tbl[15] = mk(0,1,0,0,2'd0,32'h0,        32'h304,      0,1,0,0);
    tbl[16] = mk(0,0,0,0,2'd0,32'h0,        32'h400,      1,0,0,0);
    tbl[17] = mk(0,0,0,0,2'd0,32'h0,        32'h404,      0,0,0,0);
    tbl[18] = mk(0,1,0,1,2'd0,32'h400,      32'h404,      0,1,0,0);
    tbl[19] = mk(0,1,0,1,2'd1,32'h500,      32'h404,      0,1,0,0);
    tbl[20] = mk(0,0,0,0,2'd0,32'h0,        32'h500,      1,0,0,0);
    tbl[21] = mk(0,0,0,0,2'd0,32'h0,        32'h504,      0,0,0,0);
    tbl[22] = mk(0,0,0,1,2'd3,32'h900,      32'h508,      0,0,1,0);
    tbl[23] = mk(0,0,0,0,2'd0,32'h0,        32'h50C,      0,0,1,0);
    tbl[24] = mk(0,1,0,1,2'd0,32'h600,      32'h50C,      0,1,1,0);
    tbl[25] = mk(0,1,1,0,2'd0,32'h0,        32'h50C,      0,0,1,1);

    reset = 1; stall = 0; halt = 0; redirect_valid = 0; sel_addr = 0;
    jump_addr = 0; branch_addr = 0; reg_addr = 0;
    model_step(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Directed table: non-selected targets carry distractor values
    for (int i = 0; i < 26; i++) begin
      j = (tbl[i].sel == 2'd0) ? tbl[i].addr : 32'hDEAD0000;
      b = (tbl[i].sel == 2'd1) ? tbl[i].addr : 32'hBEEF0000;
      r = (tbl[i].sel == 2'd2) ? tbl[i].addr : 32'hCAFE0000;
      step(tbl[i].rst, tbl[i].stl, tbl[i].hlt, tbl[i].rv, tbl[i].sel, j, b, r);
      check($sformatf("vec%0d.pc", i),      pc,           tbl[i].e_pc);
      check($sformatf("vec%0d.flush", i),   32'(flush),   32'(tbl[i].e_flush));
      check($sformatf("vec%0d.pending", i), 32'(pending), 32'(tbl[i].e_pend));
      check($sformatf("vec%0d.sel_err", i), 32'(sel_err), 32'(tbl[i].e_err));
      check($sformatf("vec%0d.halted", i),  32'(halted),  32'(tbl[i].e_halt));
    end

    // HALTED ignores everything but reset for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom), 1'($urandom), 1, 2'($urandom), $urandom, $urandom, $urandom);
      check($sformatf("halt%0d.pc", i),      pc,           32'h50C);
      check($sformatf("halt%0d.flush", i),   32'(flush),   32'h0);
      check($sformatf("halt%0d.pending", i), 32'(pending), 32'h0);
      check($sformatf("halt%0d.halted", i),  32'(halted),  32'h1);
    end
    step(1, 1, 1, 1, 2'd0, 32'h700, 32'h0, 32'h0);
    check("rst.pc",      pc,           32'h0);
    check("rst.flush",   32'(flush),   32'h0);
    check("rst.pending", 32'(pending), 32'h0);
    check("rst.sel_err", 32'(sel_err), 32'h0);
    check("rst.halted",  32'(halted),  32'h0);
    step(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    check("post_rst.pc", pc, 32'h4);

    // Reset while a redirect is buffered must discard it
    step(0, 1, 0, 1, 2'd2, 32'h0, 32'h0, 32'h880);
    step(1, 1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
    check("rst_hold.pc",    pc,         32'h4);
    check("rst_hold.flush", 32'(flush), 32'h0);

    // Randomized traffic against the model, targets sometimes near the wrap point
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      hlt = ($urandom_range(0, 39) == 0);
      stl = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 1) == 0);
      s   = 2'($urandom);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : 32'h0;
      j = base | ($urandom & 32'h0000FFFC);
      b = base | ($urandom & 32'h0000FFFC);
      r = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      step(rst, stl, hlt, rv, s, j, b, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
